puf_crp_sequencer: RTL and testbench

//  Drives the arbiter-PUF array: issues 8-bit challenges, generates the launch edge on the
//  PUF pulse net, and collects the 7-bit response over repeated evaluations.

---
 rtl/puf_pkg.sv | 19 +
 rtl/puf_crp_sequencer_if.sv | 27 ++
 rtl/puf_lfsr8.sv | 27 ++
 rtl/puf_crp_sequencer.sv | 170 +++++++++++++++++
 tb/tb_puf_crp_sequencer.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/puf_pkg.sv
// Shared widths, LFSR constants and FSM state type for the arbiter-PUF CRP sequencer.
package puf_pkg;

  localparam int CHAL_W = 8;
  localparam int RESP_W = 7;

  // x^8 + x^6 + x^5 + x^4 + 1 on a left-shifting register: taps at bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS         = 8'hB8;
  localparam logic [7:0] LFSR_SEED_DEFAULT = 8'h01;

  typedef enum logic [2:0] {
    IDLE,
    LOW,
    HIGH,
    VOTE,
    OUT
  } state_e;

endpackage

// File: rtl/puf_crp_sequencer_if.sv
// Valid/ready stream carrying voted challenge/response pairs to the readout logic.
interface puf_crp_sequencer_if;
  import puf_pkg::*;

  logic              resp_valid;
  logic              resp_ready;
  logic [CHAL_W-1:0] resp_challenge;
  logic [RESP_W-1:0] resp_data;
  logic [RESP_W-1:0] resp_unstable;

  modport master (
    output resp_valid,
    output resp_challenge,
    output resp_data,
    output resp_unstable,
    input  resp_ready
  );

  modport slave (
    input  resp_valid,
    input  resp_challenge,
    input  resp_data,
    input  resp_unstable,
    output resp_ready
  );

endinterface

// File: rtl/puf_lfsr8.sv
// 8-bit Fibonacci LFSR producing the challenge sequence; a zero seed is replaced so it never locks up.
module puf_lfsr8
  import puf_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       step,
  output logic [7:0] value
);

  logic [7:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= '0;
    end else if (load) begin
      lfsr_q <= (seed == '0) ? LFSR_SEED_DEFAULT : seed;
    end else if (step) begin
      lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/puf_crp_sequencer.sv
// Launches repeated arbiter-PUF evaluations per challenge, majority-votes each response bit
// and streams the resulting CRP out on a valid/ready interface.
module puf_crp_sequencer
  import puf_pkg::*;
#(
  parameter int VOTES      = 7,
  parameter int SETTLE_CYC = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   mode,
  input  logic [CHAL_W-1:0]      chal_in,
  input  logic [7:0]             burst_len,
  output logic [CHAL_W-1:0]      puf_challenge,
  output logic                   puf_launch,
  input  logic [RESP_W-1:0]      puf_response,
  output logic                   busy,
  puf_crp_sequencer_if.master    rsp
);

  localparam int CW = $clog2(VOTES + 1);
  localparam int TW = $clog2(SETTLE_CYC + 2);

  localparam logic [TW-1:0] LOW_LAST  = TW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] HIGH_LAST = TW'(SETTLE_CYC + 1);
  localparam logic [CW-1:0] EV_LAST   = CW'(VOTES - 1);
  localparam logic [CW-1:0] MAJ       = CW'(VOTES / 2);
  localparam logic [CW-1:0] ALL       = CW'(VOTES);

  state_e                       state_q, state_d;
  logic [TW-1:0]                timer_q, timer_d;
  logic [CW-1:0]                evals_q, evals_d;
  logic [7:0]                   rem_q, rem_d;
  logic                         mode_q, mode_d;
  logic [CHAL_W-1:0]            fix_q, fix_d;
  logic [RESP_W-1:0][CW-1:0]    cnt_q, cnt_d;
  logic [RESP_W-1:0]            sync1_q, sync2_q;
  logic [CHAL_W-1:0]            rchal_q, rchal_d;
  logic [RESP_W-1:0]            rdata_q, rdata_d;
  logic [RESP_W-1:0]            runst_q, runst_d;
  logic                         launch_q;
  logic                         lfsr_load, lfsr_step;
  logic [CHAL_W-1:0]            lfsr_val;

  puf_lfsr8 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .seed  (chal_in),
    .step  (lfsr_step),
    .value (lfsr_val)
  );

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    evals_d   = evals_q;
    rem_d     = rem_q;
    mode_d    = mode_q;
    fix_d     = fix_q;
    cnt_d     = cnt_q;
    rchal_d   = rchal_q;
    rdata_d   = rdata_q;
    runst_d   = runst_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mode_d    = mode;
          fix_d     = chal_in;
          rem_d     = (burst_len == '0) ? 8'd1 : burst_len;
          lfsr_load = 1'b1;
          timer_d   = '0;
          evals_d   = '0;
          state_d   = LOW;
        end
      end
      LOW: begin
        if (timer_q == LOW_LAST) begin
          timer_d = '0;
          state_d = HIGH;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      HIGH: begin
        if (timer_q == HIGH_LAST) begin
          timer_d = '0;
          for (int unsigned i = 0; i < RESP_W; i++) begin
            cnt_d[i] = cnt_q[i] + CW'(sync2_q[i]);
          end
          if (evals_q == EV_LAST) begin
            evals_d = '0;
            state_d = VOTE;
          end else begin
            evals_d = evals_q + 1'b1;
            state_d = LOW;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      VOTE: begin
        for (int unsigned i = 0; i < RESP_W; i++) begin
          rdata_d[i] = (cnt_q[i] > MAJ);
          runst_d[i] = (cnt_q[i] != '0) && (cnt_q[i] != ALL);
        end
        cnt_d   = '0;
        rchal_d = puf_challenge;
        state_d = OUT;
      end
      OUT: begin
        if (rsp.resp_ready) begin
          if (rem_q == 8'd1) begin
            state_d = IDLE;
          end else begin
            // Challenge only advances here, so it is settled before the next launch.
            rem_d     = rem_q - 8'd1;
            lfsr_step = mode_q;
            state_d   = LOW;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      evals_q  <= '0;
      rem_q    <= '0;
      mode_q   <= 1'b0;
      fix_q    <= '0;
      cnt_q    <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      rchal_q  <= '0;
      rdata_q  <= '0;
      runst_q  <= '0;
      launch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      evals_q  <= evals_d;
      rem_q    <= rem_d;
      mode_q   <= mode_d;
      fix_q    <= fix_d;
      cnt_q    <= cnt_d;
      sync1_q  <= puf_response;
      sync2_q  <= sync1_q;
      rchal_q  <= rchal_d;
      rdata_q  <= rdata_d;
      runst_q  <= runst_d;
      launch_q <= (state_d == HIGH);
    end
  end

  assign puf_challenge      = mode_q ? lfsr_val : fix_q;
  assign puf_launch         = launch_q;
  assign busy               = (state_q != IDLE);
  assign rsp.resp_valid     = (state_q == OUT);
  assign rsp.resp_challenge = rchal_q;
  assign rsp.resp_data      = rdata_q;
  assign rsp.resp_unstable  = runst_q;

endmodule

// File: tb/tb_puf_crp_sequencer.sv
// Directed bench for puf_crp_sequencer driven by a behavioural PUF: response = chal[6:0] ^ 7'h0E.
module tb_puf_crp_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] chal_in = '0;
  logic [7:0] burst_len = '0;
  logic [7:0] puf_challenge;
  logic       puf_launch;
  logic [6:0] puf_response = '0;
  logic       busy;

  int checks = 0;
  int failures = 0;

  logic noise_en = 1'b0;
  int   noise_start = 0;
  int   eval_idx = 0;
  int   stab_err = 0;
  logic launch_prev = 1'b0;
  logic [7:0] chal_prev = '0;

  puf_crp_sequencer_if rif ();

  puf_crp_sequencer #(
    .VOTES      (7),
    .SETTLE_CYC (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .mode          (mode),
    .chal_in       (chal_in),
    .burst_len     (burst_len),
    .puf_challenge (puf_challenge),
    .puf_launch    (puf_launch),
    .puf_response  (puf_response),
    .busy          (busy),
    .rsp           (rif)
  );

  always #5 clk = ~clk;

  // Behavioural PUF: sample on launch rising edge; optional bit-0 toggle, 1 on even evaluations.
  always @(posedge puf_launch) begin
    logic [6:0] r;
    int k;
    r = puf_challenge[6:0] ^ 7'h0E;
    k = eval_idx - noise_start;
    if (noise_en) r[0] = ~k[0];
    eval_idx = eval_idx + 1;
    puf_response = r;
  end

  always @(negedge clk) begin
    if (puf_launch && launch_prev && (puf_challenge !== chal_prev)) stab_err = stab_err + 1;
    launch_prev = puf_launch;
    chal_prev = puf_challenge;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_burst(input logic m, input logic [7:0] c, input logic [7:0] bl);
    @(negedge clk);
    start = 1'b1; mode = m; chal_in = c; burst_len = bl;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!rif.resp_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic handshake();
    rif.resp_ready = 1'b1;
    @(negedge clk);
    rif.resp_ready = 1'b0;
  endtask

  initial begin
    int n;
    int bad;
    logic [7:0] exp_c [3];
    logic [6:0] exp_d [3];
    logic [7:0] s_chal;
    logic [6:0] s_data, s_unst;
    exp_c = '{8'h01, 8'h02, 8'h04};
    exp_d = '{7'h0F, 7'h0C, 7'h0A};
    rif.resp_ready = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", rif.resp_valid, 0);
    check("rst_launch", puf_launch, 0);
    check("rst_chal", puf_challenge, 0);
    rst_n = 1'b1;

    // 1: fixed A5, single CRP, latency 71
    start_burst(1'b0, 8'hA5, 8'd1);
    check("t1_busy", busy, 1);
    check("t1_chal", puf_challenge, 8'hA5);
    wait_valid(n);
    check("t1_latency", n, 71);
    check("t1_rchal", rif.resp_challenge, 8'hA5);
    check("t1_rdata", rif.resp_data, 7'h2B);
    check("t1_runst", rif.resp_unstable, 0);
    check("t1_launch_out", puf_launch, 0);
    handshake();
    check("t1_busy_end", busy, 0);
    check("t1_valid_end", rif.resp_valid, 0);

    // 2: noisy bit 0, 4 ones of 7
    noise_start = eval_idx;
    noise_en = 1'b1;
    start_burst(1'b0, 8'h3C, 8'd1);
    wait_valid(n);
    check("t2_latency", n, 71);
    check("t2_rdata", rif.resp_data, 7'h33);
    check("t2_runst", rif.resp_unstable, 7'h01);
    handshake();
    noise_en = 1'b0;

    // 3: LFSR, seed 0, three CRPs
    start_burst(1'b1, 8'h00, 8'd3);
    for (int k = 0; k < 3; k++) begin
      wait_valid(n);
      check("t3_latency", n, 71);
      check("t3_rchal", rif.resp_challenge, exp_c[k]);
      check("t3_rdata", rif.resp_data, exp_d[k]);
      handshake();
      check("t3_busy_after_hs", busy, (k < 2) ? 1 : 0);
    end
    repeat (5) @(negedge clk);
    check("t3_idle", busy, 0);

    // 4: stall 20 cycles in OUT with a stray start
    start_burst(1'b0, 8'h5A, 8'd1);
    wait_valid(n);
    check("t4_latency", n, 71);
    s_chal = rif.resp_challenge; s_data = rif.resp_data; s_unst = rif.resp_unstable;
    check("t4_rdata", s_data, 7'h54);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (k == 10) begin start = 1'b1; mode = 1'b1; chal_in = 8'h77; burst_len = 8'd4; end
      if (k == 11) start = 1'b0;
      @(negedge clk);
      if (rif.resp_valid !== 1'b1 || puf_launch !== 1'b0 || rif.resp_challenge !== 8'h5A ||
          rif.resp_data !== s_data || rif.resp_unstable !== s_unst) bad++;
    end
    check("t4_stall_stable", bad, 0);
    check("t4_chal_hold", puf_challenge, 8'h5A);
    handshake();
    check("t4_busy_end", busy, 0);

    // 5: reset mid-HIGH of second CRP
    start_burst(1'b0, 8'hA5, 8'd2);
    wait_valid(n);
    handshake();
    repeat (6) @(negedge clk);
    check("t5_in_high", puf_launch, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_busy", busy, 0);
    check("t5_launch", puf_launch, 0);
    check("t5_valid", rif.resp_valid, 0);
    check("t5_chal", puf_challenge, 0);
    check("t5_rchal", rif.resp_challenge, 0);
    check("t5_rdata", rif.resp_data, 0);
    check("t5_runst", rif.resp_unstable, 0);
    rst_n = 1'b1;
    start_burst(1'b1, 8'h10, 8'd1);
    wait_valid(n);
    check("t5_latency", n, 71);
    check("t5_new_rchal", rif.resp_challenge, 8'h10);
    check("t5_new_rdata", rif.resp_data, 7'h1E);
    check("t5_new_runst", rif.resp_unstable, 0);
    handshake();
    check("t5_busy_end", busy, 0);

    // 6: burst_len 0 yields one CRP
    start_burst(1'b0, 8'hC3, 8'd0);
    wait_valid(n);
    check("t6_latency", n, 71);
    check("t6_rdata", rif.resp_data, 7'h4D);
    handshake();
    check("t6_busy_end", busy, 0);
    bad = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (rif.resp_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("t6_single_crp", bad, 0);
    check("chal_stable_during_launch", stab_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
